// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave endpoint: FSM states, SPI mode
// encodings and the default word width.
package spi_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall
// detection against one extra delayed copy of the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_dly  <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled SCLK/SS_N/MOSI, all four CPOL/CPHA modes,
// LSB-first, single-entry TX buffer and RX_VALID strobe per completed word.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic             SCLK,
  input  logic             SS_N,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LOAD,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             BUSY,
  output logic             FRAME_ERR
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic w_sclk_rise, w_sclk_fall, w_sclk_unused_lvl;
  logic w_ss_rise, w_ss_fall, w_ss_unused_lvl;
  logic w_mosi, w_mosi_unused_rise, w_mosi_unused_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_async (SCLK),
    .o_level (w_sclk_unused_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // SS_N idles high, so a deselected slave sees no false frame start after reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_async (SS_N),
    .o_level (w_ss_unused_lvl),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_async (MOSI),
    .o_level (w_mosi),
    .o_rise  (w_mosi_unused_rise),
    .o_fall  (w_mosi_unused_fall)
  );

  state_t           r_state, w_state_next;
  logic             r_cpol, r_cpha;
  logic [WIDTH-1:0] r_tx, r_rx, r_rx_data, r_tx_buf;
  logic             r_tx_full;
  logic [CW-1:0]    r_cnt;
  logic             r_skip_first, r_reload_pending;
  logic             r_miso, r_rx_valid, r_frame_err;

  logic             w_start, w_stop, w_sample, w_shift;
  logic             w_sample_edge, w_shift_edge;
  logic             w_accept, w_consume;
  logic [WIDTH-1:0] w_load_word, w_rx_next;

  always_comb begin
    w_sample_edge = 1'b0;
    w_shift_edge  = 1'b0;
    case ({r_cpol, r_cpha})
      MODE0, MODE3: begin
        w_sample_edge = w_sclk_rise;
        w_shift_edge  = w_sclk_fall;
      end
      MODE1, MODE2: begin
        w_sample_edge = w_sclk_fall;
        w_shift_edge  = w_sclk_rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_start      = 1'b1;
          w_state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_ss_rise) begin
          w_stop       = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_sample = w_sample_edge;
          w_shift  = w_shift_edge;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_load_word = r_tx_full ? r_tx_buf : '0;
  assign w_rx_next   = {w_mosi, r_rx[WIDTH-1:1]};
  assign w_accept    = TX_LOAD & ~r_tx_full;
  assign w_consume   = w_start | (w_shift & ~r_skip_first & r_reload_pending);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cpol           <= 1'b0;
      r_cpha           <= 1'b0;
      r_tx             <= '0;
      r_rx             <= '0;
      r_rx_data        <= '0;
      r_tx_buf         <= '0;
      r_tx_full        <= 1'b0;
      r_cnt            <= '0;
      r_skip_first     <= 1'b0;
      r_reload_pending <= 1'b0;
      r_miso           <= 1'b0;
      r_rx_valid       <= 1'b0;
      r_frame_err      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      // A load into an empty buffer wins over a same-cycle consume, which took zeros.
      if (w_accept) begin
        r_tx_buf  <= TX_DATA;
        r_tx_full <= 1'b1;
      end else if (w_consume) begin
        r_tx_full <= 1'b0;
      end

      if (w_start) begin
        r_cpol           <= CPOL;
        r_cpha           <= CPHA;
        r_tx             <= w_load_word;
        r_miso           <= w_load_word[0];
        r_rx             <= '0;
        r_cnt            <= '0;
        r_skip_first     <= CPHA;
        r_reload_pending <= 1'b0;
      end else if (w_stop) begin
        r_miso           <= 1'b0;
        r_frame_err      <= (r_cnt != '0);
        r_cnt            <= '0;
        r_skip_first     <= 1'b0;
        r_reload_pending <= 1'b0;
      end else begin
        if (w_sample) begin
          r_rx <= w_rx_next;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_rx_data        <= w_rx_next;
            r_rx_valid       <= 1'b1;
            r_cnt            <= '0;
            r_reload_pending <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        if (w_shift) begin
          if (r_skip_first) begin
            r_skip_first <= 1'b0;
          end else if (r_reload_pending) begin
            r_tx             <= w_load_word;
            r_miso           <= w_load_word[0];
            r_reload_pending <= 1'b0;
          end else begin
            r_tx   <= r_tx >> 1;
            r_miso <= r_tx[1];
          end
        end
      end
    end
  end

  assign MISO      = r_miso;
  assign MISO_OE   = (r_state == ACTIVE);
  assign BUSY      = (r_state == ACTIVE);
  assign TX_READY  = ~r_tx_full;
  assign RX_DATA   = r_rx_data;
  assign RX_VALID  = r_rx_valid;
  assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master, RX/FRAME_ERR monitor and a
// queue-based TX buffer model for randomized frames.
module tb_spi_slave;

  localparam int H = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CPOL = 1'b0, CPHA = 1'b0, SCLK = 1'b0, SS_N = 1'b1, MOSI = 1'b0;
  logic       MISO, MISO_OE, TX_READY, RX_VALID, BUSY, FRAME_ERR;
  logic [7:0] TX_DATA = '0;
  logic       TX_LOAD = 1'b0;
  logic [7:0] RX_DATA;

  int n_cmp = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int oe_bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] model_buf[$];
  logic cur_cpol, cur_cpha;

  spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .CPOL(CPOL), .CPHA(CPHA), .SCLK(SCLK),
    .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE),
    .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (RX_VALID) rx_q.push_back(RX_DATA);
      if (FRAME_ERR) fe_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic tx_load(input logic [7:0] d);
    TX_DATA = d;
    TX_LOAD = 1'b1;
    cyc(1);
    TX_LOAD = 1'b0;
  endtask

  task automatic model_load(input logic [7:0] d);
    if (model_buf.size() == 0) model_buf.push_back(d);
  endtask

  function automatic logic [7:0] model_take();
    if (model_buf.size() == 0) return 8'h00;
    return model_buf.pop_front();
  endfunction

  task automatic frame_begin(input logic cpol, input logic cpha);
    cur_cpol = cpol;
    cur_cpha = cpha;
    CPOL = cpol;
    CPHA = cpha;
    SCLK = cpol;
    cyc(10);
    SS_N = 1'b0;
    cyc(H);
    CPOL = 1'($urandom);
    CPHA = 1'($urandom);
  endtask

  task automatic frame_end();
    cyc(H);
    SS_N = 1'b1;
    cyc(12);
  endtask

  task automatic master_bits(input logic [7:0] d, input int n, output logic [7:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      if (!cur_cpha) begin
        MOSI = d[i];
        cyc(H);
        m[i] = MISO;
        if (!MISO_OE || !BUSY) oe_bad++;
        SCLK = ~cur_cpol;
        cyc(H);
        SCLK = cur_cpol;
      end else begin
        SCLK = ~cur_cpol;
        MOSI = d[i];
        cyc(H);
        m[i] = MISO;
        if (!MISO_OE || !BUSY) oe_bad++;
        SCLK = cur_cpol;
        cyc(H);
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] got, exp;
    cyc(3);
    exp = {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    got = {MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, BUSY, FRAME_ERR};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got, exp);
    end
    RESET = 1'b0;
    cyc(5);
  endtask

  task automatic test_mode0();
    logic [7:0] m;
    int n0, fe0;
    n0 = rx_q.size(); fe0 = fe_cnt; oe_bad = 0;
    tx_load(8'hA3);
    n_cmp++;
    if (TX_READY !== 1'b0) begin n_fail++; $display("FAIL mode0_ready_after_load: got %b expected 0", TX_READY); end
    frame_begin(1'b0, 1'b0);
    n_cmp++;
    if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL mode0_ready_after_ssfall: got %b expected 1", TX_READY); end
    master_bits(8'h55, 8, m);
    frame_end();
    n_cmp++;
    if (m !== 8'hA3) begin n_fail++; $display("FAIL mode0_miso: got %h expected a3", m); end
    n_cmp++;
    if (rx_q.size() != n0 + 1) begin
      n_fail++; $display("FAIL mode0_rxvalid_count: got %0d expected 1", rx_q.size() - n0);
    end else if (rx_q[n0] !== 8'h55) begin
      n_fail++; $display("FAIL mode0_rxdata: got %h expected 55", rx_q[n0]);
    end
    n_cmp++;
    if (oe_bad != 0 || fe_cnt != fe0) begin
      n_fail++; $display("FAIL mode0_oe_fe: oe_bad %0d fe %0d expected 0 0", oe_bad, fe_cnt - fe0);
    end
  endtask

  task automatic test_modes();
    logic [7:0] mo[3], tx[3];
    logic [7:0] m;
    int n0;
    mo = '{8'h33, 8'h6D, 8'hAA};
    tx = '{8'hCC, 8'h92, 8'h0F};
    for (int k = 0; k < 3; k++) begin
      logic [1:0] md;
      md = 2'(k + 1);
      n0 = rx_q.size();
      tx_load(tx[k]);
      frame_begin(md[1], md[0]);
      master_bits(mo[k], 8, m);
      frame_end();
      n_cmp++;
      if (m !== tx[k]) begin n_fail++; $display("FAIL mode%0d_miso: got %h expected %h", k + 1, m, tx[k]); end
      n_cmp++;
      if (rx_q.size() != n0 + 1 || RX_DATA !== mo[k]) begin
        n_fail++;
        $display("FAIL mode%0d_rx: got %h (%0d words) expected %h (1 word)", k + 1, RX_DATA, rx_q.size() - n0, mo[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m0, m1;
    int n0;
    n0 = rx_q.size();
    tx_load(8'hF0);
    fork
      begin
        frame_begin(1'b0, 1'b0);
        master_bits(8'h12, 8, m0);
        master_bits(8'h34, 8, m1);
        frame_end();
      end
      begin : loader
        int k;
        k = 0;
        while (rx_q.size() == n0 && k < 400) begin cyc(1); k++; end
        n_cmp++;
        if (rx_q.size() == n0) begin
          n_fail++; $display("FAIL b2b_first_rxvalid: got none within 400 cycles expected 1");
        end else begin
          tx_load(8'h0F);
        end
      end
    join
    n_cmp++;
    if (rx_q.size() != n0 + 2) begin
      n_fail++; $display("FAIL b2b_rx_count: got %0d expected 2", rx_q.size() - n0);
    end else if (rx_q[n0] !== 8'h12 || rx_q[n0 + 1] !== 8'h34) begin
      n_fail++; $display("FAIL b2b_rx_seq: got %h %h expected 12 34", rx_q[n0], rx_q[n0 + 1]);
    end
    n_cmp++;
    if (m0 !== 8'hF0 || m1 !== 8'h0F) begin
      n_fail++; $display("FAIL b2b_miso: got %h %h expected f0 0f", m0, m1);
    end
  endtask

  task automatic test_empty_ignored();
    logic [7:0] m;
    frame_begin(1'b0, 1'b1);
    master_bits(8'h3C, 8, m);
    frame_end();
    n_cmp++;
    if (m !== 8'h00) begin n_fail++; $display("FAIL empty_miso: got %h expected 00", m); end
    tx_load(8'h5A);
    tx_load(8'hC3);
    n_cmp++;
    if (TX_READY !== 1'b0) begin n_fail++; $display("FAIL ignored_ready: got %b expected 0", TX_READY); end
    frame_begin(1'b1, 1'b1);
    master_bits(8'h01, 8, m);
    frame_end();
    n_cmp++;
    if (m !== 8'h5A) begin n_fail++; $display("FAIL ignored_keeps_first: got %h expected 5a", m); end
  endtask

  task automatic test_abort();
    logic [7:0] m, prev;
    int n0, fe0;
    prev = RX_DATA; n0 = rx_q.size(); fe0 = fe_cnt;
    frame_begin(1'b0, 1'b0);
    master_bits(8'hFF, 5, m);
    frame_end();
    n_cmp++;
    if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d pulses expected 1", fe_cnt - fe0); end
    n_cmp++;
    if (rx_q.size() != n0 || RX_DATA !== prev) begin
      n_fail++; $display("FAIL abort_rx_hold: got %h (%0d words) expected %h (0 words)", RX_DATA, rx_q.size() - n0, prev);
    end
    n_cmp++;
    if ({MISO_OE, MISO, BUSY} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle_outputs: got %b expected 000", {MISO_OE, MISO, BUSY});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    logic [13:0] got, exp;
    int n0, fe0;
    fe0 = fe_cnt;
    tx_load(8'h77);
    frame_begin(1'b0, 1'b0);
    master_bits(8'hE5, 3, m);
    tx_load(8'h99);
    RESET = 1'b1;
    SS_N = 1'b1;
    cyc(1);
    exp = {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    got = {MISO, MISO_OE, TX_READY, RX_DATA, RX_VALID, BUSY, FRAME_ERR};
    n_cmp++;
    if (got !== exp) begin n_fail++; $display("FAIL midreset_values: got %h expected %h", got, exp); end
    RESET = 1'b0;
    cyc(10);
    n0 = rx_q.size();
    frame_begin(1'b0, 1'b0);
    master_bits(8'h81, 8, m);
    frame_end();
    n_cmp++;
    if (rx_q.size() != n0 + 1 || RX_DATA !== 8'h81 || m !== 8'h00 || fe_cnt != fe0) begin
      n_fail++;
      $display("FAIL midreset_recover: got rx %h words %0d miso %h fe %0d expected 81 1 00 0",
               RX_DATA, rx_q.size() - n0, m, fe_cnt - fe0);
    end
  endtask

  task automatic test_random();
    logic [7:0] mo[2], exp_m[2], m;
    logic [1:0] md;
    int nw, n0;
    model_buf.delete();
    for (int it = 0; it < 12; it++) begin
      md = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 2);
      if ($urandom_range(0, 9) < 7) begin
        logic [7:0] d;
        d = 8'($urandom);
        tx_load(d); model_load(d);
        if ($urandom_range(0, 1) == 1) begin
          d = 8'($urandom);
          tx_load(d); model_load(d);
        end
      end
      n_cmp++;
      if (TX_READY !== (model_buf.size() == 0)) begin
        n_fail++; $display("FAIL rand%0d_ready_pre: got %b expected %b", it, TX_READY, model_buf.size() == 0);
      end
      n0 = rx_q.size();
      frame_begin(md[1], md[0]);
      for (int w = 0; w < nw; w++) begin
        mo[w] = 8'($urandom);
        exp_m[w] = model_take();
        master_bits(mo[w], 8, m);
        n_cmp++;
        if (m !== exp_m[w]) begin
          n_fail++; $display("FAIL rand%0d_w%0d_miso: mode %0d got %h expected %h", it, w, md, m, exp_m[w]);
        end
      end
      if (md[0] == 1'b0) void'(model_take());
      frame_end();
      for (int w = 0; w < nw; w++) begin
        n_cmp++;
        if (rx_q.size() <= n0 + w || rx_q[n0 + w] !== mo[w]) begin
          n_fail++;
          $display("FAIL rand%0d_w%0d_rx: got %h (%0d words) expected %h", it, w,
                   (rx_q.size() > n0 + w) ? rx_q[n0 + w] : 8'hxx, rx_q.size() - n0, mo[w]);
        end
      end
      n_cmp++;
      if (TX_READY !== (model_buf.size() == 0)) begin
        n_fail++; $display("FAIL rand%0d_ready_post: got %b expected %b", it, TX_READY, model_buf.size() == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_empty_ignored();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave endpoint; the peripheral-side counterpart to the team's SPI master, one instance per slave-select line.
- Oversamples SCLK, SS_N and MOSI on the system clock CLK, supports all four CPOL/CPHA modes, LSB-first on the wire.
- Exchanges one WIDTH-bit word per byte-slot with the host logic through a single-entry TX buffer and an RX_VALID strobe.

Parameters:
- WIDTH, 8, shift length per word.
- SYNC_STAGES, 2, synchronizer flops on SCLK, SS_N and MOSI (minimum 2).

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CPOL  in  1  SCLK idle level; sampled at frame start.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at frame start.
- SCLK  in  1  serial clock from master, asynchronous.
- SS_N  in  1  slave select, active low, asynchronous.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master; 0 when not driven.
- MISO_OE  out  1  tristate enable; high only while a frame is active.
- TX_DATA  in  WIDTH  word to transmit.
- TX_LOAD  in  1  write strobe for TX_DATA; accepted only when TX_READY=1.
- TX_READY  out  1  TX buffer empty.
- RX_DATA  out  WIDTH  last complete received word; held until the next word completes.
- RX_VALID  out  1  one-cycle pulse when RX_DATA updates.
- BUSY  out  1  frame active.
- FRAME_ERR  out  1  one-cycle pulse when SS_N deasserts mid-word.

Behaviour:
- Reset values: MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0, RX_VALID=0, BUSY=0, FRAME_ERR=0. Reset also sets state=IDLE, counter=0, and clears the TX buffer and all shift registers. Reset mid-frame aborts silently with no FRAME_ERR.
- Input sync: SCLK, SS_N and MOSI pass through SYNC_STAGES flops. Edge detection compares the synchronized value with one extra delayed copy. Latency from pin edge to internal event is SYNC_STAGES+1 CLK cycles.
- Timing requirement: each SCLK half-period must be at least SYNC_STAGES+2 CLK cycles.
- Edge definitions:
  - Leading edge = SCLK transition away from the latched CPOL level; trailing edge = transition back.
  - CPHA=0: sample edge = leading, shift edge = trailing.
  - CPHA=1: sample edge = trailing, shift edge = leading.
- TX buffer:
  - TX_LOAD while TX_READY=1 stores TX_DATA and drops TX_READY the next cycle.
  - TX_LOAD while TX_READY=0 is ignored and does not overwrite the buffer.
  - The buffer is consumed at each word load, and TX_READY rises the next cycle.
  - Empty buffer at a word load: transmit all zeros.
- State IDLE:
  - BUSY=0, MISO_OE=0.
  - On synced SS_N falling: latch CPOL/CPHA, load the TX shift register from the buffer, drive MISO=tx[0], set BUSY=1 and MISO_OE=1, set counter=0, go to ACTIVE.
  - For CPHA=1, also set skip_first so the first shift edge does not shift.
- State ACTIVE:
  - Sample edge: rx <= {MOSI_sync, rx[WIDTH-1:1]}; counter++.
  - Shift edge:
    - If skip_first, clear it with no shift.
    - Else if reload_pending, load tx from the buffer, drive MISO=tx[0], clear reload_pending.
    - Else tx >>= 1 and MISO = next bit.
  - When the sample makes counter==WIDTH: RX_DATA <= the completed rx word and RX_VALID pulses on the same cycle; counter <= 0; reload_pending <= 1. The frame continues for back-to-back words.
  - Synced SS_N rising: go to IDLE; MISO_OE=0 and MISO=0 the next cycle; BUSY=0.
  - SS_N rising with counter != 0: FRAME_ERR pulses, the partial word is discarded and RX_DATA is unchanged.
  - An unconsumed reload_pending at SS_N rise is cleared and the buffer is untouched.
- Simultaneous events:
  - SS_N falling and TX_LOAD in the same cycle: the frame loads the old buffer contents (zeros if empty); the new word is accepted into the buffer.
  - SCLK edges while SS_N is high are ignored.
- Mode changes: CPOL/CPHA changes while BUSY=1 have no effect until the next frame.

Decomposition:
- Package spi_pkg holds:
  - state enum {IDLE, ACTIVE};
  - mode encoding constants MODE0..MODE3 = {CPOL,CPHA};
  - default WIDTH.
- Sub-module spi_sync_edge: one synchronizer plus rise/fall detector. Instantiate three times (SCLK, SS_N, MOSI); the MOSI instance uses only the level output.

Test Plan:
- Mode 0: TX_LOAD 0xA3, master sends 0x55 LSB-first at 8 CLK/half-period -> RX_DATA=0x55 with a single RX_VALID pulse; MISO bits seen by master 1,1,0,0,0,1,0,1; TX_READY=1 after SS_N fall.
- Modes 1, 2, 3: exchange 0x33/0xCC, 0x6D/0x92, 0xAA/0x0F -> each RX_DATA is correct and the master receives the loaded word in every mode.
- Back-to-back: one SS_N frame of two words 0x12 then 0x34, with TX 0xF0 loaded and then 0x0F loaded after the first RX_VALID -> RX_DATA sequence 0x12, 0x34; master receives 0xF0, 0x0F.
- Empty buffer / ignored load: start a frame with no load -> master receives 0x00; a second TX_LOAD while TX_READY=0 -> the buffer keeps the first value.
- Abort: SS_N rises after 5 SCLK cycles -> FRAME_ERR pulse, no RX_VALID, RX_DATA holds its previous value, MISO_OE=0.
- RESET asserted mid-word after 3 bits -> all outputs at reset values the next cycle; the following clean 0x81 frame is received correctly.
